// File: rtl/ttl_74669_pre_if.sv
`default_nettype none
// ============================================================================
// Module      : ttl_74669_pre_if
// Description : Control, data and status bundle for the 74669-style
//               synchronous up/down counter. The master side drives load,
//               direction, enables and parallel data; the counter (slave)
//               returns its state and the active-low ripple carry/borrow.
// Revision    : 1.0 - initial release
// ============================================================================
interface ttl_74669_pre_if #(
    parameter int WIDTH = 4
);
    logic             Load_bar;
    logic             U_D;
    logic             ENP_bar;
    logic             ENT_bar;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             RCO_bar;

    modport master (
        output Load_bar,
        output U_D,
        output ENP_bar,
        output ENT_bar,
        output D,
        input  Q,
        input  RCO_bar
    );

    modport slave (
        input  Load_bar,
        input  U_D,
        input  ENP_bar,
        input  ENT_bar,
        input  D,
        output Q,
        output RCO_bar
    );
endinterface
`default_nettype wire

// File: rtl/ttl_74669_pre.sv
`default_nettype none
// ============================================================================
// Module      : ttl_74669_pre
// Description : Synchronous presettable up/down binary counter modelled on
//               the 74669. Asynchronous active-low preset forces all-ones;
//               synchronous load beats counting; ENT_bar gates both counting
//               and the ripple carry/borrow so stages cascade directly.
// Revision    : 1.0 - initial release
// ============================================================================
module ttl_74669_pre #(
    parameter int WIDTH      = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  wire logic        Clk,
    input  wire logic        Preset_bar,
    ttl_74669_pre_if.slave   bus
);

    // Counter state; starts at zero in simulation before any preset.
    logic [WIDTH-1:0] r_count = '0;
    logic [WIDTH-1:0] w_count_next;
    logic             w_count_en;
    logic             w_terminal;
    logic             w_rco_bar;

    // Both enables must be asserted for a count; ENP_bar alone never touches the carry.
    assign w_count_en = !bus.ENP_bar && !bus.ENT_bar;

    // Terminal state depends on direction: all-ones counting up, zero counting down.
    assign w_terminal = bus.U_D ? (r_count == {WIDTH{1'b1}})
                                : (r_count == {WIDTH{1'b0}});

    // Carry/borrow is purely combinational so the next stage sees it before the shared edge.
    assign w_rco_bar = !(!bus.ENT_bar && w_terminal);

    // Next-state selection: load has priority over count, otherwise hold.
    always_comb begin
        w_count_next = r_count;
        if (!bus.Load_bar) begin
            w_count_next = bus.D;
        end else if (w_count_en) begin
            if (bus.U_D) begin
                w_count_next = r_count + WIDTH'(1);
            end else begin
                w_count_next = r_count - WIDTH'(1);
            end
        end
    end

    // State register; preset is asynchronous and overrides the clock entirely.
    always_ff @(posedge Clk or negedge Preset_bar) begin
        if (!Preset_bar) begin
            r_count <= {WIDTH{1'b1}};
        end else begin
            r_count <= w_count_next;
        end
    end

    // Output buffers carry the only timing in the model.
    assign #(DELAY_RISE, DELAY_FALL) bus.Q       = r_count;
    assign #(DELAY_RISE, DELAY_FALL) bus.RCO_bar = w_rco_bar;

endmodule
`default_nettype wire

// File: doc/ttl_74669_pre.md
TTL_74669_PRE -- requirements
Module: ttl_74669_pre

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 1..16.
REQ-002 Parameter DELAY_RISE, default 0: output rise delay in ns, applied to Q and RCO_bar.
REQ-003 Parameter DELAY_FALL, default 0: output fall delay in ns, applied to Q and RCO_bar.
REQ-004 Clk  input  1  counter clock; all synchronous actions occur on the rising edge.
REQ-005 Preset_bar  input  1  reset, asynchronous, active-low.
REQ-006 Load_bar  input  1  synchronous parallel load, active-low.
REQ-007 U_D  input  1  count direction: 1 = up, 0 = down.
REQ-008 ENP_bar  input  1  parallel count enable, active-low; does not gate RCO_bar.
REQ-009 ENT_bar  input  1  trickle count enable, active-low; gates counting and RCO_bar.
REQ-010 D  input  WIDTH  parallel load data.
REQ-011 Q  output  WIDTH  counter state.
REQ-012 RCO_bar  output  1  ripple carry/borrow out, active-low, for cascading.

Function
REQ-013 Priority on each rising Clk edge SHALL be: Preset_bar low > Load_bar low > count > hold.
REQ-014 With Load_bar=0, the next Q SHALL be D, regardless of ENP_bar, ENT_bar and U_D.
REQ-015 With Load_bar=1, ENP_bar=0, ENT_bar=0 and U_D=1, the next Q SHALL be Q+1 modulo 2^WIDTH; all-ones SHALL wrap to 0.
REQ-016 With Load_bar=1, ENP_bar=0, ENT_bar=0 and U_D=0, the next Q SHALL be Q-1 modulo 2^WIDTH; 0 SHALL wrap to all-ones.
REQ-017 With Load_bar=1 and either ENP_bar=1 or ENT_bar=1, Q SHALL hold.
REQ-018 RCO_bar SHALL be combinational and SHALL be 0 only when ENT_bar=0 and either (U_D=1 and Q=all-ones) or (U_D=0 and Q=0); otherwise it SHALL be 1.
REQ-019 RCO_bar SHALL be independent of ENP_bar, Load_bar and Clk.
REQ-020 A change of U_D SHALL take effect for the next count edge, and SHALL update RCO_bar immediately (subject to delays) without altering Q.
REQ-021 Latency: Q SHALL update one Clk edge after load or count conditions are sampled; no pipeline stages.
REQ-022 Cascading: connecting stage n RCO_bar to stage n+1 ENT_bar, with a shared Clk, ENP_bar and U_D, SHALL yield a synchronous (n+1)*WIDTH-bit up/down counter without extra logic.
REQ-023 Inputs sampled at a Clk edge SHALL be the values present before that edge (nonblocking update semantics).
REQ-024 Q and RCO_bar SHALL be driven through #(DELAY_RISE, DELAY_FALL); there SHALL be no other timing in the RTL.

Reset
REQ-025 Preset_bar falling SHALL force Q to all-ones immediately, without waiting for Clk.
REQ-026 While Preset_bar=0, Q SHALL remain all-ones and Clk, Load_bar and the enables SHALL be ignored.
REQ-027 After Preset_bar returns high, the first rising Clk edge SHALL apply REQ-013..REQ-017 normally.
REQ-028 If Preset_bar asserts mid-count, the count in progress SHALL be discarded and Q SHALL be all-ones.
REQ-029 Reset value of RCO_bar SHALL follow REQ-018 from Q=all-ones; for example, it SHALL be 0 if ENT_bar=0 and U_D=1.
REQ-030 The pre-reset simulation value of Q SHALL be 0.

Verification
REQ-031 Preset: WIDTH=4, pulse Preset_bar low between edges -> Q=4'hF at once; with ENT_bar=0 and U_D=1 -> RCO_bar=0.
REQ-032 Load priority: Load_bar=0, D=4'h5, ENP_bar=ENT_bar=0, U_D=0, one edge -> Q=4'h5, not 4'h4.
REQ-033 Up wrap: Q=4'hE, U_D=1, enables low, two edges -> Q=4'hF then 4'h0; RCO_bar=0 only while Q=4'hF.
REQ-034 Down wrap: Q=4'h1, U_D=0, enables low, two edges -> Q=4'h0 then 4'hF; RCO_bar=0 only while Q=4'h0.
REQ-035 Enable gating: Q=4'hF, U_D=1, ENP_bar=1 and ENT_bar=0 -> Q holds and RCO_bar=0; with ENT_bar=1 -> RCO_bar=1.
REQ-036 Cascade: two instances chained RCO_bar->ENT_bar and loaded with 8'h0F, one up edge -> 8'h10; then U_D=0, one edge -> 8'h0F.
